alu_seq: RTL

//   Parametrised multi-cycle ALU: add/sub/mul/div on WIDTH-bit unsigned operands. Results are 2*WIDTH wide.

---
 rtl/alu_seq_pkg.sv | 16 +
 rtl/alu_seq_muldiv_iter.sv | 53 +++++
 rtl/alu_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM states and flag bit positions shared by the alu_seq files
package alu_seq_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;
    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_DIV0  = 3;
endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// alu_seq_muldiv_iter: shared WIDTH-step shift-add multiplier / restoring divider with start/done pulses
module alu_seq_muldiv_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    logic               run_q, div_q, div_c, take;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_c, acc_d, y_q, y_c, y_d;
    logic [WIDTH-1:0]   x_q, x_c, x_d;
    logic [WIDTH:0]     rem_sh, rem_sub;
    // one step per cycle; the first step runs on the start edge straight from the operands
    always_comb begin
        div_c    = start_i ? is_div_i : div_q;
        acc_c    = start_i ? '0 : acc_q;
        x_c      = start_i ? a_i : x_q;
        y_c      = start_i ? {{WIDTH{1'b0}}, b_i} : y_q;
        rem_sh   = {acc_c[WIDTH-1:0], x_c[WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, y_c[WIDTH-1:0]};
        take     = rem_sh >= {1'b0, y_c[WIDTH-1:0]};
        acc_d    = div_c ? {{(WIDTH-1){1'b0}}, take ? rem_sub : rem_sh} : acc_c + (x_c[0] ? y_c : '0);
        x_d      = div_c ? {x_c[WIDTH-2:0], take} : x_c >> 1;
        y_d      = div_c ? y_c : y_c << 1;
        done_o   = run_q && cnt_q == CNT_W'(WIDTH - 1);
        result_o = div_c ? {acc_d[WIDTH-1:0], x_d} : acc_d;
    end
    // step registers advance while running; counter counts completed steps and stops at WIDTH
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else if (start_i || run_q) begin
            run_q <= start_i || !done_o;
            div_q <= div_c;
            cnt_q <= start_i ? CNT_W'(1) : cnt_q + 1'b1;
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle unsigned add/sub/mul/div with valid/ready handshakes on both sides
// Optional {div0, ovf, carry, zero} flags output when ALU_SEQ_FLAGS_EN is defined.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [1:0]         op_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
`ifdef ALU_SEQ_FLAGS_EN
    output logic [3:0]         flags_o,
`endif
    output logic [2*WIDTH-1:0] result_o
);
    state_e             state_q;
    logic               in_ready_q, out_valid_q, md_start, md_done;
    logic [2*WIDTH-1:0] result_q, md_res, as_res;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   dif;
    // single-cycle add/sub datapath and multi-cycle launch decode
    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        dif      = a_i - b_i;
        as_res   = {{(WIDTH-1){1'b0}}, op_i == OP_SUB ? {1'b0, dif} : sum};
        md_start = state_q == ST_IDLE && in_valid_i && (op_i == OP_MUL || op_i == OP_DIV);
    end
    alu_seq_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (md_start),
        .is_div_i (op_i == OP_DIV),
        .a_i      (a_i),
        .b_i      (b_i),
        .done_o   (md_done),
        .result_o (md_res)
    );
    // control FSM: registered handshake outputs, result captured on completion and held until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid_i) begin
                    state_q     <= md_start ? ST_BUSY : ST_DONE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= !md_start;
                    if (!md_start) result_q <= as_res;
                end
                ST_BUSY: if (md_done) begin
                    state_q     <= ST_DONE;
                    out_valid_q <= 1'b1;
                    result_q    <= md_res;
                end
                ST_DONE: if (out_ready_i) begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
`ifdef ALU_SEQ_FLAGS_EN
    logic [3:0] flags_q, as_flg, md_flg;
    logic       div_q, bz_q;
    // flag values for the single-cycle and iterative result paths
    always_comb begin
        as_flg            = '0;
        as_flg[FLG_ZERO]  = as_res == '0;
        as_flg[FLG_CARRY] = op_i == OP_SUB ? a_i < b_i : sum[WIDTH];
        md_flg            = '0;
        md_flg[FLG_ZERO]  = md_res == '0;
        md_flg[FLG_OVF]   = !div_q && md_res[2*WIDTH-1:WIDTH] != '0;
        md_flg[FLG_DIV0]  = div_q && bz_q;
    end
    // flags load with the result and hold with it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= '0;
            div_q   <= 1'b0;
            bz_q    <= 1'b0;
        end else if (state_q == ST_IDLE && in_valid_i) begin
            div_q <= op_i == OP_DIV;
            bz_q  <= b_i == '0;
            if (!md_start) flags_q <= as_flg;
        end else if (state_q == ST_BUSY && md_done) begin
            flags_q <= md_flg;
        end
    end
    assign flags_o = flags_q;
`endif
endmodule
